// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction-fetch front end with an in-order prefetch queue.
//
// Generates word-addressed fetch PCs and issues pipelined requests to
// instruction memory. It uses a req/gnt/rvalid handshake, and responses return
// in request order. Each returned instruction is stored with its PC in a
// DEPTH-entry queue that feeds decode. A redirect flushes the queue, restarts
// fetch at the new PC, and silently drops every response still in flight.
//
// Ports:
//   i_clk, i_rst_n                 clock (rising edge), async active-low reset
//   i_start / i_halt               pulses: IDLE/HALT -> RUN, RUN -> HALT
//   i_redirect, i_redirect_pc      flush and restart fetch at i_redirect_pc
//   o_imem_req, o_imem_addr        fetch request and word address
//   i_imem_gnt                     request accepted when o_imem_req & i_imem_gnt
//   i_imem_rvalid, i_imem_rdata    in-order response
//   o_inst_valid, o_inst, o_inst_pc  queue head presented to decode
//   i_inst_ready                   decode pops the head when valid & ready
//   o_count                        current queue occupancy
module inst_fetch_queue #(
   parameter int unsigned     PC_W     = 32,
   parameter int unsigned     INST_W   = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_start,
   input  logic                   i_halt,
   input  logic                   i_redirect,
   input  logic [PC_W-1:0]        i_redirect_pc,
   output logic                   o_imem_req,
   output logic [PC_W-1:0]        o_imem_addr,
   input  logic                   i_imem_gnt,
   input  logic                   i_imem_rvalid,
   input  logic [INST_W-1:0]      i_imem_rdata,
   output logic                   o_inst_valid,
   output logic [INST_W-1:0]      o_inst,
   output logic [PC_W-1:0]        o_inst_pc,
   input  logic                   i_inst_ready,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   logic [1:0]      state_q,    state_d;
   logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0] resp_pc_q,  resp_pc_d;
   logic [CW-1:0]   count_q,    count_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   discard_q,  discard_d;
   logic [AW-1:0]   head_q,     head_d;
   logic [AW-1:0]   tail_q,     tail_d;

   logic [INST_W-1:0] inst_mem_q [DEPTH];
   logic [PC_W-1:0]   pc_mem_q   [DEPTH];

   logic          grant;
   logic          push;
   logic          pop;
   logic [CW:0]   used;

   // Credit: queued entries plus outstanding requests never exceed DEPTH,
   // so every response always has a free slot waiting for it.
   assign used         = {1'b0, count_q} + {1'b0, inflight_q};
   assign o_imem_req   = (state_q == S_RUN) && !i_redirect && (used < (CW+1)'(DEPTH));
   assign o_imem_addr  = fetch_pc_q;
   assign o_inst_valid = (count_q != '0);
   assign o_inst       = o_inst_valid ? inst_mem_q[head_q] : '0;
   assign o_inst_pc    = o_inst_valid ? pc_mem_q[head_q]   : '0;
   assign o_count      = count_q;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      count_d    = count_q;
      inflight_d = inflight_q;
      discard_d  = discard_q;
      head_d     = head_q;
      tail_d     = tail_q;
      grant      = o_imem_req & i_imem_gnt;
      push       = 1'b0;
      pop        = 1'b0;

      case (state_q)
         S_IDLE:  if (i_start) state_d = S_RUN;
         S_RUN:   if (i_halt)  state_d = S_HALT;
         S_HALT:  if (i_start) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase

      if (i_redirect) begin
         // Every request still outstanding, except one answered this cycle,
         // returns stale data and must be dropped on arrival.
         count_d    = '0;
         head_d     = '0;
         tail_d     = '0;
         fetch_pc_d = i_redirect_pc;
         resp_pc_d  = i_redirect_pc;
         inflight_d = inflight_q - CW'(i_imem_rvalid);
         discard_d  = inflight_q - CW'(i_imem_rvalid);
      end else begin
         pop = o_inst_valid & i_inst_ready;
         if (grant) fetch_pc_d = fetch_pc_q + PC_W'(1);
         inflight_d = inflight_q + CW'(grant) - CW'(i_imem_rvalid);
         if (i_imem_rvalid) begin
            if (discard_q != '0) begin
               discard_d = discard_q - CW'(1);
            end else begin
               push      = 1'b1;
               resp_pc_d = resp_pc_q + PC_W'(1);
            end
         end
         if (push) tail_d = tail_q + AW'(1);
         if (pop)  head_d = head_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         count_q    <= '0;
         inflight_q <= '0;
         discard_q  <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         inst_mem_q[tail_q] <= i_imem_rdata;
         pc_mem_q[tail_q]   <= resp_pc_q;
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: self-checking bench for inst_fetch_queue.
//
// A directed vector table, hand-written corner sequences and a randomized run.
// The reference model keeps the prefetch queue as a queue of {inst, pc}. It
// tags each outstanding request with a redirect epoch. A response is kept only
// when its epoch is current and no redirect happens in the same cycle. A second
// instance, started at a PC just below the top, checks address wrap-around.
module tb_inst_fetch_queue;

   localparam int DEPTH = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 0, i_halt = 0, i_redirect = 0;
   logic [31:0] i_redirect_pc = '0;
   logic        i_imem_gnt = 0, i_imem_rvalid = 0, i_inst_ready = 0;
   logic [31:0] i_imem_rdata = '0;
   logic        o_imem_req, o_inst_valid;
   logic [31:0] o_imem_addr, o_inst, o_inst_pc;
   logic [2:0]  o_count;

   logic        w_start = 0, w_gnt = 0, w_zero = 0;
   logic [31:0] w_zpc = '0, w_zdata = '0;
   logic        w_req, w_valid;
   logic [31:0] w_addr, w_inst, w_pc;
   logic [2:0]  w_count;

   always #5 clk = ~clk;

   inst_fetch_queue #(.PC_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_halt(i_halt),
      .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
      .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
      .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
      .i_inst_ready(i_inst_ready), .o_count(o_count));

   inst_fetch_queue #(.PC_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFE)) dut_w (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(w_start), .i_halt(w_zero),
      .i_redirect(w_zero), .i_redirect_pc(w_zpc),
      .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_gnt(w_gnt),
      .i_imem_rvalid(w_zero), .i_imem_rdata(w_zdata),
      .o_inst_valid(w_valid), .o_inst(w_inst), .o_inst_pc(w_pc),
      .i_inst_ready(w_zero), .o_count(w_count));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Protocol monitor: a response with nothing outstanding is illegal.
   int mon_out;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mon_out <= 0;
      else mon_out <= mon_out + int'(o_imem_req && i_imem_gnt) - int'(i_imem_rvalid);
   end
   always @(posedge clk) begin
      if (rst_n && i_imem_rvalid)
         assert (mon_out > 0) else $error("protocol: rvalid with no request outstanding");
   end

   // ---------------- reference model ----------------
   typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
   typedef struct { logic [31:0] addr; int unsigned epoch; } req_t;
   ent_t        q[$];
   req_t        pend[$];
   int          m_state;
   logic [31:0] m_fetch;
   int unsigned m_epoch;

   task automatic model_reset();
      q.delete();
      pend.delete();
      m_state = M_IDLE;
      m_fetch = 32'h0;
      m_epoch = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      i_start = 0; i_halt = 0; i_redirect = 0; i_redirect_pc = '0;
      i_imem_gnt = 0; i_imem_rvalid = 0; i_imem_rdata = '0; i_inst_ready = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One cycle: drive at the negedge, check mid-cycle, advance the model, wait a cycle.
   task automatic step(input bit st, input bit hl, input bit rd, input logic [31:0] rpc,
                       input bit g, input bit rv, input bit rdy);
      bit   rv_eff, m_req, do_push;
      ent_t e;
      req_t r;
      rv_eff = rv && (pend.size() != 0);
      i_start = st; i_halt = hl; i_redirect = rd; i_redirect_pc = rpc;
      i_imem_gnt = g; i_imem_rvalid = rv_eff; i_imem_rdata = $urandom; i_inst_ready = rdy;
      m_req = (m_state == M_RUN) && !rd && ((q.size() + pend.size()) < DEPTH);
      #1;
      chk("req", o_imem_req, m_req);
      chk("addr", o_imem_addr, m_fetch);
      chk("valid", o_inst_valid, q.size() != 0);
      chk("count", o_count, q.size());
      if (q.size() != 0) begin
         chk("inst", o_inst, q[0].inst);
         chk("inst_pc", o_inst_pc, q[0].pc);
      end
      do_push = 0;
      if (rv_eff) begin
         r = pend.pop_front();
         if (!rd && r.epoch == m_epoch) begin
            e.inst = i_imem_rdata;
            e.pc = r.addr;
            do_push = 1;
         end
      end
      if (!rd && q.size() != 0 && rdy) void'(q.pop_front());
      if (do_push) q.push_back(e);
      if (m_req && g) begin
         pend.push_back('{addr: m_fetch, epoch: m_epoch});
         m_fetch = m_fetch + 32'd1;
      end
      if (rd) begin
         q.delete();
         m_epoch++;
         m_fetch = rpc;
      end
      if (m_state == M_RUN && hl) m_state = M_HALT;
      else if (m_state != M_RUN && st) m_state = M_RUN;
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit st, hl, rd; logic [31:0] rpc; bit g, rv; logic [31:0] rdata; bit rdy;
      bit e_req; logic [31:0] e_addr; bit e_val; logic [31:0] e_inst, e_pc; int e_cnt;
   } vec_t;

   function automatic vec_t mk(bit st, bit hl, bit rd, logic [31:0] rpc, bit g, bit rv,
                               logic [31:0] rdata, bit rdy, bit er, logic [31:0] ea,
                               bit ev, logic [31:0] ei, logic [31:0] ep, int ec);
      vec_t v;
      v.st = st; v.hl = hl; v.rd = rd; v.rpc = rpc; v.g = g; v.rv = rv; v.rdata = rdata;
      v.rdy = rdy; v.e_req = er; v.e_addr = ea; v.e_val = ev; v.e_inst = ei; v.e_pc = ep;
      v.e_cnt = ec;
      return v;
   endfunction

   vec_t tbl[17];

   initial begin
      logic [31:0] saved;
      int guard;

      //                st hl rd rpc     g rv rdata     rdy  req addr     val inst      pc     cnt
      tbl[0]  = mk(0, 0, 0, 32'h0,  0, 0, 32'h0,    0,  0, 32'h0,  0, 32'h0,    32'h0,  0);
      tbl[1]  = mk(1, 0, 0, 32'h0,  0, 0, 32'h0,    0,  0, 32'h0,  0, 32'h0,    32'h0,  0);
      tbl[2]  = mk(0, 0, 0, 32'h0,  1, 0, 32'h0,    0,  1, 32'h0,  0, 32'h0,    32'h0,  0);
      tbl[3]  = mk(0, 0, 0, 32'h0,  1, 1, 32'h1000, 1,  1, 32'h1,  0, 32'h0,    32'h0,  0);
      tbl[4]  = mk(0, 0, 0, 32'h0,  1, 1, 32'h1001, 1,  1, 32'h2,  1, 32'h1000, 32'h0,  1);
      tbl[5]  = mk(0, 0, 0, 32'h0,  1, 1, 32'h1002, 0,  1, 32'h3,  1, 32'h1001, 32'h1,  1);
      tbl[6]  = mk(0, 0, 0, 32'h0,  1, 1, 32'h1003, 0,  1, 32'h4,  1, 32'h1001, 32'h1,  2);
      tbl[7]  = mk(0, 0, 0, 32'h0,  1, 1, 32'h1004, 0,  0, 32'h5,  1, 32'h1001, 32'h1,  3);
      tbl[8]  = mk(0, 0, 0, 32'h0,  1, 0, 32'h0,    0,  0, 32'h5,  1, 32'h1001, 32'h1,  4);
      tbl[9]  = mk(0, 0, 0, 32'h0,  1, 0, 32'h0,    1,  0, 32'h5,  1, 32'h1001, 32'h1,  4);
      tbl[10] = mk(0, 0, 0, 32'h0,  1, 0, 32'h0,    0,  1, 32'h5,  1, 32'h1002, 32'h2,  3);
      tbl[11] = mk(0, 0, 1, 32'h40, 1, 1, 32'h1005, 1,  0, 32'h6,  1, 32'h1002, 32'h2,  3);
      tbl[12] = mk(0, 0, 0, 32'h0,  1, 0, 32'h0,    0,  1, 32'h40, 0, 32'h0,    32'h0,  0);
      tbl[13] = mk(1, 1, 0, 32'h0,  0, 1, 32'h2040, 0,  1, 32'h41, 0, 32'h0,    32'h0,  0);
      tbl[14] = mk(0, 0, 0, 32'h0,  1, 0, 32'h0,    0,  0, 32'h41, 1, 32'h2040, 32'h40, 1);
      tbl[15] = mk(1, 0, 0, 32'h0,  0, 0, 32'h0,    1,  0, 32'h41, 1, 32'h2040, 32'h40, 1);
      tbl[16] = mk(0, 0, 0, 32'h0,  1, 0, 32'h0,    0,  1, 32'h41, 0, 32'h0,    32'h0,  0);

      model_reset();
      #2;
      chk("rst_req", o_imem_req, 1'b0);
      chk("rst_addr", o_imem_addr, 32'h0);
      chk("rst_valid", o_inst_valid, 1'b0);
      chk("rst_count", o_count, 3'd0);
      chk("rst_inst", o_inst, 32'h0);
      chk("rst_inst_pc", o_inst_pc, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Address wrap on the second instance.
      chk("wrap_rst_addr", w_addr, 32'hFFFF_FFFE);
      w_start = 1;
      @(posedge clk); @(negedge clk);
      w_start = 0; w_gnt = 1; #1;
      chk("wrap_req", w_req, 1'b1);
      chk("wrap_addr0", w_addr, 32'hFFFF_FFFE);
      @(posedge clk); @(negedge clk);
      chk("wrap_addr1", w_addr, 32'hFFFF_FFFF);
      @(posedge clk); @(negedge clk);
      chk("wrap_addr2", w_addr, 32'h0);
      chk("wrap_req2", w_req, 1'b1);
      w_gnt = 0;

      // Directed table.
      do_reset();
      for (int i = 0; i < 17; i++) begin
         i_start = tbl[i].st; i_halt = tbl[i].hl; i_redirect = tbl[i].rd;
         i_redirect_pc = tbl[i].rpc; i_imem_gnt = tbl[i].g; i_imem_rvalid = tbl[i].rv;
         i_imem_rdata = tbl[i].rdata; i_inst_ready = tbl[i].rdy;
         #1;
         chk($sformatf("tbl%0d_req", i), o_imem_req, tbl[i].e_req);
         chk($sformatf("tbl%0d_addr", i), o_imem_addr, tbl[i].e_addr);
         chk($sformatf("tbl%0d_valid", i), o_inst_valid, tbl[i].e_val);
         chk($sformatf("tbl%0d_count", i), o_count, tbl[i].e_cnt);
         if (tbl[i].e_val) begin
            chk($sformatf("tbl%0d_inst", i), o_inst, tbl[i].e_inst);
            chk($sformatf("tbl%0d_pc", i), o_inst_pc, tbl[i].e_pc);
         end
         @(posedge clk); @(negedge clk);
      end

      // Redirect while three requests (addr 5,6,7) are outstanding.
      do_reset();
      step(1, 0, 0, 0, 0, 0, 0);
      guard = 0;
      while (m_fetch != 32'd5 && guard < 40) begin step(0, 0, 0, 0, 1, 1, 1); guard++; end
      guard = 0;
      while ((pend.size() != 0 || q.size() != 0) && guard < 20) begin
         step(0, 0, 0, 0, 0, 1, 1); guard++;
      end
      for (int k = 0; k < 3; k++) begin
         chk("burst_addr", o_imem_addr, 32'd5 + 32'(k));
         step(0, 0, 0, 0, 1, 0, 1);
      end
      step(0, 0, 1, 32'h40, 1, 1, 1);
      chk("redir_count", o_count, 3'd0);
      chk("redir_addr", o_imem_addr, 32'h40);
      guard = 0;
      while (q.size() == 0 && guard < 20) begin step(0, 0, 0, 0, 1, 1, 0); guard++; end
      chk("redir_first_valid", o_inst_valid, 1'b1);
      chk("redir_first_pc", o_inst_pc, 32'h40);

      // Grant held low: address and queue stay put.
      guard = 0;
      while ((pend.size() != 0 || q.size() != 0) && guard < 20) begin
         step(0, 0, 0, 0, 0, 1, 1); guard++;
      end
      saved = m_fetch;
      repeat (5) step(0, 0, 0, 0, 0, 0, 1);
      chk("stall_addr", o_imem_addr, saved);
      chk("stall_count", o_count, 3'd0);
      step(0, 0, 0, 0, 1, 0, 1);
      chk("stall_resume", o_imem_addr, saved + 32'd1);

      // Halt with two outstanding and one queued.
      guard = 0;
      while ((pend.size() != 0 || q.size() != 0) && guard < 20) begin
         step(0, 0, 0, 0, 0, 1, 1); guard++;
      end
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 1, 0);
      chk("halt_count", o_count, 3'd3);
      chk("halt_req", o_imem_req, 1'b0);
      guard = 0;
      while (q.size() != 0 && guard < 10) begin step(0, 0, 0, 0, 1, 0, 1); guard++; end
      chk("halt_drained", o_count, 3'd0);
      saved = m_fetch;
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("halt_resume_addr", o_imem_addr, saved + 32'd1);

      // Asynchronous reset in the middle of a burst.
      repeat (3) step(0, 0, 0, 0, 1, 1, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req", o_imem_req, 1'b0);
      chk("arst_valid", o_inst_valid, 1'b0);
      chk("arst_count", o_count, 3'd0);
      chk("arst_inst", o_inst, 32'h0);
      chk("arst_inst_pc", o_inst_pc, 32'h0);
      chk("arst_addr", o_imem_addr, 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step(0, 0, 0, 0, 1, 1, 1);
      step(1, 0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 0, 1, 0, 1);

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         step(($urandom % 100) < 6, ($urandom % 100) < 3, ($urandom % 100) < 3, $urandom,
              ($urandom % 10) < 7, ($urandom % 10) < 7, ($urandom % 10) < 6);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
